// File: rtl/kanagawa_multi_fifo_monitor_pkg.sv
// Shared types and defaults for the multi-FIFO monitor.
// Error codes are shared by the first-error record and the bench.
package kanagawa_fifo_monitor_pkg;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2
    } fifo_err_t;

    localparam int DEFAULT_TS_WIDTH = 32;

endpackage

// File: rtl/kanagawa_multi_fifo_monitor_channel.sv
// One monitored FIFO: sticky overflow/underflow flags, shadow occupancy and high-water mark.
// The interface is level-based only (no valid/ready handshake): every input is sampled each clk edge.
module kanagawa_fifo_monitor_channel
    import kanagawa_fifo_monitor_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             full,
    input  logic             wren,
    input  logic             empty,
    input  logic             rden,
    input  logic             clear,
    output logic             ovf_evt,
    output logic             unf_evt,
    output logic             overflow,
    output logic             underflow,
    output logic [OCC_W-1:0] occ,
    output logic [OCC_W-1:0] hwm
);

    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);

    logic             acc_wr;
    logic             acc_rd;
    logic [OCC_W-1:0] occ_next;

`ifdef NO_DYNAMIC_ASSERTS
    assign ovf_evt = 1'b0;
    assign unf_evt = 1'b0;
`else
    assign ovf_evt = full & wren;
    assign unf_evt = empty & rden;
`endif

    assign acc_wr = wren & ~full;
    assign acc_rd = rden & ~empty;

    always_comb begin
        occ_next = occ;
        if (acc_wr && !acc_rd && occ != DEPTH_V)
            occ_next = occ + OCC_W'(1);
        else if (acc_rd && !acc_wr && occ != '0)
            occ_next = occ - OCC_W'(1);
    end

    // A clear re-arms the HWM from where the FIFO is heading, not from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            occ       <= '0;
            hwm       <= '0;
        end else begin
            occ <= occ_next;
            if (clear) begin
                overflow  <= ovf_evt;
                underflow <= unf_evt;
                hwm       <= occ_next;
            end else begin
                overflow  <= overflow | ovf_evt;
                underflow <= underflow | unf_evt;
                if (occ_next > hwm)
                    hwm <= occ_next;
            end
        end
    end

endmodule

// File: rtl/kanagawa_multi_fifo_monitor.sv
// Monitors NUM_CHANNELS FIFOs: sticky error flags, first-error capture with timestamp,
// and a registered per-channel occupancy/high-water-mark query port.
module kanagawa_multi_fifo_monitor
    import kanagawa_fifo_monitor_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 32,
    parameter int TS_WIDTH     = DEFAULT_TS_WIDTH,
    parameter int SEL_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int OCC_W        = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CHANNELS-1:0] full_in,
    input  logic [NUM_CHANNELS-1:0] wren_in,
    input  logic [NUM_CHANNELS-1:0] empty_in,
    input  logic [NUM_CHANNELS-1:0] rden_in,
    input  logic                    clear_in,
    input  logic [SEL_W-1:0]        sel_in,
    output logic [NUM_CHANNELS-1:0] overflow_out,
    output logic [NUM_CHANNELS-1:0] underflow_out,
    output logic                    error_out,
    output logic                    first_valid_out,
    output logic [SEL_W-1:0]        first_chan_out,
    output fifo_err_t               first_type_out,
    output logic [TS_WIDTH-1:0]     first_ts_out,
    output logic [OCC_W-1:0]        occ_out,
    output logic [OCC_W-1:0]        hwm_out
);

    logic [NUM_CHANNELS-1:0] ovf_vec;
    logic [NUM_CHANNELS-1:0] unf_vec;
    logic [OCC_W-1:0]        occ_arr [NUM_CHANNELS];
    logic [OCC_W-1:0]        hwm_arr [NUM_CHANNELS];
    logic [TS_WIDTH-1:0]     ts;
    logic                    any_evt;
    logic [SEL_W-1:0]        evt_chan;
    fifo_err_t               evt_type;
    logic [OCC_W-1:0]        occ_sel;
    logic [OCC_W-1:0]        hwm_sel;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        kanagawa_fifo_monitor_channel #(
            .DEPTH (DEPTH),
            .OCC_W (OCC_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .full      (full_in[g]),
            .wren      (wren_in[g]),
            .empty     (empty_in[g]),
            .rden      (rden_in[g]),
            .clear     (clear_in),
            .ovf_evt   (ovf_vec[g]),
            .unf_evt   (unf_vec[g]),
            .overflow  (overflow_out[g]),
            .underflow (underflow_out[g]),
            .occ       (occ_arr[g]),
            .hwm       (hwm_arr[g])
        );
    end

    assign any_evt   = |(ovf_vec | unf_vec);
    assign error_out = (|overflow_out) | (|underflow_out);

    // Scan high-to-low so the lowest offending channel wins; overflow beats underflow.
    always_comb begin
        evt_chan = '0;
        evt_type = ERR_NONE;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (ovf_vec[i] || unf_vec[i]) begin
                evt_chan = SEL_W'(i);
                evt_type = ovf_vec[i] ? ERR_OVERFLOW : ERR_UNDERFLOW;
            end
        end
    end

    always_comb begin
        occ_sel = '0;
        hwm_sel = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (int'(sel_in) == i) begin
                occ_sel = occ_arr[i];
                hwm_sel = hwm_arr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts              <= '0;
            first_valid_out <= 1'b0;
            first_chan_out  <= '0;
            first_type_out  <= ERR_NONE;
            first_ts_out    <= '0;
            occ_out         <= '0;
            hwm_out         <= '0;
        end else begin
            ts      <= ts + TS_WIDTH'(1);
            occ_out <= occ_sel;
            hwm_out <= hwm_sel;
            // An event coincident with clear becomes the new first error.
            if ((clear_in || !first_valid_out) && any_evt) begin
                first_valid_out <= 1'b1;
                first_chan_out  <= evt_chan;
                first_type_out  <= evt_type;
                first_ts_out    <= ts;
            end else if (clear_in) begin
                first_valid_out <= 1'b0;
                first_chan_out  <= '0;
                first_type_out  <= ERR_NONE;
                first_ts_out    <= '0;
            end
        end
    end

endmodule

// File: doc/kanagawa_multi_fifo_monitor.md
KANAGAWA_MULTI_FIFO_MONITOR -- requirements
Module: kanagawa_multi_fifo_monitor

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of monitored FIFOs (legal 1..32).
REQ-002 SHALL have parameter DEPTH, default 32: capacity of every monitored FIFO (legal >=2).
REQ-003 SHALL have parameter TS_WIDTH, default 32: timestamp counter width.
REQ-004 Clocking and reset are decided: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 full_in  in  NUM_CHANNELS  per-channel FIFO full flag.
REQ-008 wren_in  in  NUM_CHANNELS  per-channel write request.
REQ-009 empty_in  in  NUM_CHANNELS  per-channel FIFO empty flag.
REQ-010 rden_in  in  NUM_CHANNELS  per-channel read request.
REQ-011 clear_in  in  1  synchronous clear of sticky and capture state.
REQ-012 sel_in  in  $clog2(NUM_CHANNELS) (min 1)  channel select for the statistics query.
REQ-013 overflow_out  out  NUM_CHANNELS  sticky per-channel overflow flags.
REQ-014 underflow_out  out  NUM_CHANNELS  sticky per-channel underflow flags.
REQ-015 error_out  out  1  OR of all sticky flags.
REQ-016 first_valid_out  out  1  first-error record valid.
REQ-017 first_chan_out  out  $clog2(NUM_CHANNELS) (min 1)  channel of first error.
REQ-018 first_type_out  out  2  error type of first error (package enum).
REQ-019 first_ts_out  out  TS_WIDTH  timestamp of first error.
REQ-020 occ_out  out  $clog2(DEPTH+1)  shadow occupancy of channel sel_in.
REQ-021 hwm_out  out  $clog2(DEPTH+1)  high-water mark of channel sel_in.

Function
REQ-022 Per channel c, overflow event = full_in[c] & wren_in[c]; underflow event = empty_in[c] & rden_in[c].
REQ-023 An event SHALL set the channel sticky flag on the next rising clk edge (1-cycle latency); the flag holds until clear_in or reset.
REQ-024 With `NO_DYNAMIC_ASSERTS defined, events SHALL be ignored: sticky flags, first-error record and error_out stay 0; occupancy/HWM tracking is unaffected.
REQ-025 Shadow occupancy SHALL be +1 on accepted write (wren & ~full), -1 on accepted read (rden & ~empty), unchanged when both or neither; saturates at DEPTH and 0.
REQ-026 Overflowing writes and underflowing reads SHALL NOT change occupancy.
REQ-027 HWM SHALL update to the next occupancy value whenever that value exceeds the current HWM.
REQ-028 Timestamp counter SHALL increment every cycle out of reset and wrap modulo 2^TS_WIDTH.
REQ-029 First-error record: when first_valid_out=0 and any event occurs, capture the lowest-index offending channel, its type and the current timestamp, and set first_valid_out=1 next cycle.
REQ-030 Same-channel simultaneous overflow and underflow: record type OVERFLOW; both sticky flags set.
REQ-031 Once first_valid_out=1, the record SHALL NOT change until clear_in or reset.
REQ-032 clear_in=1 SHALL zero sticky flags and the first-error record, and set every HWM to that channel's next occupancy; occupancy and timestamp are not affected.
REQ-033 An event in the same cycle as clear_in SHALL win: its flag is set and it becomes the new first error.
REQ-034 occ_out/hwm_out SHALL be registered: value reflects sel_in and state sampled at the previous edge (1-cycle latency); sel_in >= NUM_CHANNELS returns 0.
REQ-035 error_out SHALL be combinational OR of the registered sticky flags.

Reset
REQ-036 rst_n low SHALL asynchronously clear all flags, occupancies, HWMs, timestamp, first-error record, occ_out and hwm_out to 0; first_type_out = ERR_NONE.
REQ-037 Deassertion is synchronised externally; first post-reset edge counts as timestamp 0 -> 1.

Structure
REQ-038 Package kanagawa_fifo_monitor_pkg SHALL hold enum fifo_err_t {ERR_NONE=0, ERR_OVERFLOW=1, ERR_UNDERFLOW=2} and default TS_WIDTH constant.
REQ-039 Sub-module kanagawa_fifo_monitor_channel SHALL implement one channel (sticky flags, occupancy, HWM), instantiated NUM_CHANNELS times by generate; priority encoding and query mux in the top.

Verification
REQ-040 NUM_CHANNELS=4, DEPTH=4: 4 writes ch2, then 1 write with full_in[2]=1 at ts=7 -> overflow_out=4'b0100, first_chan=2, type=OVERFLOW, first_ts=7, occ(ch2)=4.
REQ-041 Same cycle underflow ch1 and overflow ch3 -> first_chan=1, type=UNDERFLOW; both flags set; later errors leave record unchanged.
REQ-042 3 writes, 2 reads, 1 simultaneous write+read on ch0 -> occ=1, hwm=3; clear_in -> hwm=1.
REQ-043 clear_in coincident with underflow on ch0 -> underflow_out=4'b0001, first_valid=1, first_chan=0.
REQ-044 rst_n pulsed low mid-run between edges -> all outputs 0 immediately, before next clk edge.
REQ-045 Build with NO_DYNAMIC_ASSERTS, repeat REQ-040 -> error_out=0, first_valid=0, occ(ch2)=4.
